// File: rtl/sklansky_sub_pipe_16_pkg.sv
// sklansky_sub_pipe_16_pkg: shared constants and stage-1 payload for the pipelined Sklansky subtractor
package sklansky_sub_pipe_16_pkg;
    localparam int W = 16;
    localparam int LAYERS = 4;
    localparam int S1_LAYERS = 2;
    typedef struct packed {
        logic [W-1:0] gp;
        logic [W-1:0] gg;
        logic [W-1:0] h;
        logic         a_msb;
        logic         b_msb;
    } s1_t;
endpackage

// File: rtl/sklansky_sub_pipe_16_if.sv
// sklansky_sub_pipe_16_if: operand/result streams with valid/ready handshakes
interface sklansky_sub_pipe_16_if;
    import sklansky_sub_pipe_16_pkg::*;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] diff;
    logic         borrow;
    logic         ovf;
    logic         zero;
    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, diff, borrow, ovf, zero
    );
    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, diff, borrow, ovf, zero
    );
endinterface

// File: rtl/sklansky_sub_pipe_16_pg_cell.sv
// sklansky_pg_cell: prefix operator merging a high group (l) with the adjacent low group (r)
module sklansky_pg_cell (
    input  logic pl,
    input  logic gl,
    input  logic pr,
    input  logic gr,
    output logic po,
    output logic go
);
    assign po = pl & pr;
    assign go = gl | (pl & gr);
endmodule

// File: rtl/sklansky_sub_pipe_16.sv
// sklansky_sub_pipe_16: two-stage A - B on a Sklansky prefix tree with borrow/overflow/zero flags
module sklansky_sub_pipe_16
    import sklansky_sub_pipe_16_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input logic clk,
    input logic rst,
    sklansky_sub_pipe_16_if.slave bus
);
    if (WIDTH != 16) begin : g_bad_width
        $error("sklansky_sub_pipe_16 supports WIDTH = 16 only");
    end
    logic [W-1:0] bi;
    logic [LAYERS:0][W-1:0] pp, gg;
    s1_t s1_d, s1_q;
    logic s1_valid, s2_valid, adv1, adv2;
    logic [W-1:0] diff_d, diff_q;
    logic borrow_q, ovf_q, zero_q;
    logic unused_p;
    assign bi = ~bus.b;
    assign pp[0] = bus.a | bi;
    // carry-in of 1 folded into bit 0, so gg[k][i] is the carry out of bit i
    assign gg[0] = (bus.a & bi) | {{(W-1){1'b0}}, bus.a[0] | bi[0]};
    for (genvar l = 1; l <= LAYERS; l++) begin : g_layer
        logic [W-1:0] pin, gin;
        if (l == S1_LAYERS + 1) begin : g_reg
            assign pin = s1_q.gp;
            assign gin = s1_q.gg;
        end else begin : g_comb
            assign pin = pp[l-1];
            assign gin = gg[l-1];
        end
        for (genvar i = 0; i < W; i++) begin : g_bit
            localparam int J = ((i >> (l - 1)) << (l - 1)) - 1;
            if (((i >> (l - 1)) & 1) == 1) begin : g_cell
                sklansky_pg_cell u_cell (
                    .pl(pin[i]),
                    .gl(gin[i]),
                    .pr(pin[J]),
                    .gr(gin[J]),
                    .po(pp[l][i]),
                    .go(gg[l][i])
                );
            end else begin : g_pass
                assign pp[l][i] = pin[i];
                assign gg[l][i] = gin[i];
            end
        end
    end
    assign unused_p = ^pp[LAYERS];
    assign s1_d = '{
        gp:    pp[S1_LAYERS],
        gg:    gg[S1_LAYERS],
        h:     bus.a ^ bi,
        a_msb: bus.a[W-1],
        b_msb: bus.b[W-1]
    };
    assign diff_d = s1_q.h ^ {gg[LAYERS][W-2:0], 1'b1};
    // IN_READY follows OUT_READY combinationally through adv2
    assign adv2 = ~s2_valid | bus.out_ready;
    assign adv1 = ~s1_valid | adv2;
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
            diff_q   <= '0;
            borrow_q <= 1'b0;
            ovf_q    <= 1'b0;
            zero_q   <= 1'b0;
        end else begin
            if (adv1) begin
                s1_valid <= bus.in_valid;
                s1_q     <= s1_d;
            end
            if (adv2) begin
                s2_valid <= s1_valid;
                diff_q   <= diff_d;
                borrow_q <= ~gg[LAYERS][W-1];
                ovf_q    <= (s1_q.a_msb != s1_q.b_msb) && (diff_d[W-1] != s1_q.a_msb);
                zero_q   <= ~|diff_d;
            end
        end
    end
    assign bus.in_ready  = adv1;
    assign bus.out_valid = s2_valid;
    assign bus.diff      = diff_q;
    assign bus.borrow    = borrow_q;
    assign bus.ovf       = ovf_q;
    assign bus.zero      = zero_q;
endmodule

// File: tb/tb_sklansky_sub_pipe_16.sv
// tb_sklansky_sub_pipe_16: directed and random checks of the pipelined subtractor against an arithmetic model
module tb_sklansky_sub_pipe_16;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int n_cmp = 0;
    int n_err = 0;
    int n_out = 0;
    logic [18:0] q[$];
    logic [18:0] got, held, expv;
    logic held_v = 1'b0;
    sklansky_sub_pipe_16_if bus ();
    sklansky_sub_pipe_16 dut (.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask
    function automatic logic [18:0] model(input logic [15:0] x, input logic [15:0] y);
        logic [16:0] f = {1'b0, x} - {1'b0, y};
        int r = int'($signed(x)) - int'($signed(y));
        return {f[15:0], f[16], (r > 32767 || r < -32768), f[15:0] == 16'h0};
    endfunction
    function automatic logic [15:0] pick();
        int s = int'($urandom_range(0, 7));
        return s == 0 ? 16'h0000 : s == 1 ? 16'hFFFF : s == 2 ? 16'h8000 :
               s == 3 ? 16'h7FFF : 16'($urandom);
    endfunction
    // scoreboard: transfers are decided by the values present just before each rising edge
    always @(negedge clk) begin
        got = {bus.diff, bus.borrow, bus.ovf, bus.zero};
        if (rst) begin
            q.delete();
            held_v = 1'b0;
        end else begin
            if (held_v) check("stall_hold", 32'(got), 32'(held));
            if (bus.out_valid && bus.out_ready) begin
                if (q.size() == 0) check("spurious_out", 32'(bus.out_valid), 32'(0));
                else begin
                    expv = q.pop_front();
                    check("result", 32'(got), 32'(expv));
                    n_out++;
                end
            end
            held_v = bus.out_valid && !bus.out_ready;
            held = got;
            if (bus.in_valid && bus.in_ready) q.push_back(model(bus.a, bus.b));
        end
    end
    task automatic run_one(input string tag, input logic [15:0] x, input logic [15:0] y,
                           input logic [18:0] exp);
        @(posedge clk); #1;
        bus.out_ready = 1'b1;
        bus.in_valid = 1'b1;
        bus.a = x;
        bus.b = y;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        @(negedge clk);
        check({tag, "_lat1"}, 32'(bus.out_valid), 32'(0));
        @(negedge clk);
        check({tag, "_lat2"}, 32'(bus.out_valid), 32'(1));
        check(tag, 32'({bus.diff, bus.borrow, bus.ovf, bus.zero}), 32'(exp));
    endtask
    initial begin
        int base, acc, cyc, k;
        logic saw_low;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        bus.a = '0;
        bus.b = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_out_valid", 32'(bus.out_valid), 32'(0));
        check("rst_in_ready", 32'(bus.in_ready), 32'(1));
        check("rst_outputs", 32'({bus.diff, bus.borrow, bus.ovf, bus.zero}), 32'(0));
        run_one("0_minus_1", 16'h0000, 16'h0001, {16'hFFFF, 1'b1, 1'b0, 1'b0});
        run_one("8000_minus_1", 16'h8000, 16'h0001, {16'h7FFF, 1'b0, 1'b1, 1'b0});
        run_one("equal", 16'h1234, 16'h1234, {16'h0000, 1'b0, 1'b0, 1'b1});
        run_one("7fff_minus_ffff", 16'h7FFF, 16'hFFFF, {16'h8000, 1'b1, 1'b1, 1'b0});
        // eight back-to-back pairs with a three-cycle consumer stall
        @(posedge clk); #1;
        base = n_out;
        k = 0;
        saw_low = 1'b0;
        for (int c = 0; c < 30; c++) begin
            bus.out_ready = !(c >= 3 && c < 6);
            bus.in_valid = k < 8;
            bus.a = 16'(k) * 16'h1111;
            bus.b = 16'h0F0F;
            @(negedge clk);
            if (bus.in_valid && bus.in_ready) k++;
            if (!bus.in_ready) saw_low = 1'b1;
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        check("stream_count", 32'(n_out - base), 32'(8));
        check("stream_ready_dropped", 32'(saw_low), 32'(1));
        // reset with two results in flight
        bus.out_ready = 1'b0;
        bus.in_valid = 1'b1;
        bus.a = 16'h0001;
        bus.b = 16'h0001;
        @(posedge clk); #1;
        bus.a = 16'h0002;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        @(negedge clk);
        check("full_in_ready", 32'(bus.in_ready), 32'(0));
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("midrst_out_valid", 32'(bus.out_valid), 32'(0));
        check("midrst_in_ready", 32'(bus.in_ready), 32'(1));
        run_one("after_rst", 16'h0005, 16'h0003, {16'h0002, 1'b0, 1'b0, 1'b0});
        // random traffic with random backpressure
        @(posedge clk); #1;
        acc = 0;
        cyc = 0;
        while (acc < 10000 && cyc < 60000) begin
            bus.in_valid = ($urandom_range(0, 9) < 7);
            bus.a = pick();
            bus.b = pick();
            bus.out_ready = ($urandom_range(0, 9) < 7);
            @(negedge clk);
            if (bus.in_valid && bus.in_ready) acc++;
            @(posedge clk); #1;
            cyc++;
        end
        check("rand_accepted", 32'(acc), 32'(10000));
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("drain", 32'(q.size()), 32'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/sklansky_sub_pipe_16.md
Name: sklansky_sub_pipe_16

Overview:
- Pipelined 16-bit subtractor, DIFF = A - B, computed as A + ~B + 1 on a Sklansky parallel-prefix carry tree.
- It is the inverse-operation companion to the combinational 16-bit Sklansky adder.
- Two register stages with valid/ready handshakes on both sides, so it can sit in a streaming datapath between a producer and a consumer.
- Flags produced: borrow, signed overflow, zero.

Parameters:
- WIDTH, 16, operand width. Only 16 is supported; any other value is an elaboration error.

Ports:
- CLK  in  1  rising-edge clock
- RST  in  1  synchronous, active-high reset
- IN_VALID  in  1  operand pair A/B valid
- IN_READY  out  1  block can accept an operand pair this cycle
- A  in  16  minuend
- B  in  16  subtrahend
- OUT_VALID  out  1  result valid
- OUT_READY  in  1  consumer accepts the result this cycle
- DIFF  out  16  A - B modulo 2^16
- BORROW  out  1  1 when unsigned A < B; equals ~carry-out
- OVF  out  1  signed overflow: (A[15] != B[15]) && (DIFF[15] != A[15])
- ZERO  out  1  DIFF == 0

Behaviour:
- One clock domain. Reset is synchronous and active-high (RST, sampled on CLK rising edge).
- Reset values:
  - s1_valid = 0, s2_valid = 0, OUT_VALID = 0.
  - DIFF, BORROW, OVF and ZERO = 0.
  - IN_READY = 1 from the first cycle after reset.
- Input transfer occurs when IN_VALID && IN_READY. Output transfer occurs when OUT_VALID && OUT_READY.
- Stage 0, combinational, before the stage-1 register:
  - Bi = ~B.
  - P[i] = A[i] | Bi[i]; G[i] = A[i] & Bi[i].
  - Carry-in of 1 is folded into bit 0: G0' = A[0] | Bi[0].
  - Prefix layers 1-2 (2-bit and 4-bit groups) are computed here.
- Stage-1 register holds: group P/G after layer 2, raw A[15], B[15], and the half-sum H = A ^ Bi.
- Stage 2, combinational, before the stage-2 register:
  - Prefix layers 3-4 (8-bit and 16-bit groups).
  - Carry into bit i: c0 = 1; c_i = group-G over bits [i-1:0], with the carry-in included.
  - DIFF[i] = H[i] ^ c_i.
  - BORROW = ~c16. OVF per the port definition. ZERO = ~|DIFF.
- Stage-2 register drives the outputs directly. No combinational path from A/B to any output.
- Latency: 2 cycles from input transfer to OUT_VALID when not stalled. Throughput: 1 result per cycle.
- Flow control:
  - adv2 = ~s2_valid | OUT_READY.
  - adv1 = ~s1_valid | adv2.
  - IN_READY = adv1.
  - Stage 2 loads when adv2, taking s1_valid as its valid.
  - Stage 1 loads when adv1, taking IN_VALID && IN_READY as its valid.
- IN_READY may depend combinationally on OUT_READY. That path is accepted and documented for integrators.
- Backpressure:
  - While OUT_VALID && !OUT_READY, DIFF/BORROW/OVF/ZERO hold stable.
  - At most 2 results are in flight. No data is dropped or duplicated.
- Bubbles: an empty stage still advances, so no gap persists behind a valid entry.
- Simultaneous events:
  - Output transfer and input transfer in the same cycle are both honoured with a full pipe.
  - A full pipe with OUT_READY = 1 accepts new input that same cycle.
- Reset mid-operation: both valids clear on the next edge and in-flight results are discarded. No OUT_VALID pulse occurs until a new input is accepted after reset.
- Data registers may load while their valid is 0. Outputs are only meaningful while OUT_VALID = 1, apart from their reset value of 0.

Decomposition:
- Shared package: constants for the Sklansky layer count (4) and the stage split (layers 1-2 in S1, layers 3-4 in S2), plus a packed struct for the stage-1 payload (gp, gg, H, a_msb, b_msb).
- One natural sub-module: sklansky_pg_cell (PO = PL & PR; GO = GL | (PL & GR)), instantiated across all prefix layers.
- The pipeline control stays inline in the top module.

Test Plan:
- A=0x0000, B=0x0001, OUT_READY=1 -> 2 cycles later DIFF=0xFFFF, BORROW=1, OVF=0, ZERO=0.
- A=0x8000, B=0x0001 -> DIFF=0x7FFF, BORROW=0, OVF=1.
- A=0x1234, B=0x1234 -> DIFF=0x0000, ZERO=1, BORROW=0, OVF=0.
- A=0x7FFF, B=0xFFFF -> DIFF=0x8000, BORROW=1, OVF=1.
- Stream of 8 back-to-back pairs (A=k*0x1111, B=0x0F0F) with OUT_READY held low for 3 cycles mid-stream:
  - IN_READY drops while both stages are full;
  - all 8 results arrive in order with correct values;
  - outputs are stable during the stall.
- RST asserted for 1 cycle with 2 results in flight -> next cycle OUT_VALID=0 and IN_READY=1; the next accepted pair (0x0005 - 0x0003) yields DIFF=0x0002 after 2 cycles.
- Random 10k pairs checked against a reference model (A - B), including the BORROW, OVF and ZERO flags, under random OUT_READY.
